move_arbiter: RTL and testbench

Input sequencer for the TicTacToe board controller. Takes the five raw player buttons and grants at most one action per press, using fixed priority and a shared post-release lockout timer. It keeps the 3x3 cursor position and the X/O turn. Accepted selects on free cells go out as single-cycle placement pulses to the board-state logic.

---
 rtl/move_arbiter.sv | 121 ++++++++++++
 tb/tb_move_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/move_arbiter.sv
// move_arbiter: turns raw player buttons into one-shot cursor moves and cell placements for TicTacToe.
//   clk, rst (async, active-low)
//   btn_up/down/left/right/sel : synchronized level requests
//   occupied[8:0], game_active : board status, sampled at the grant edge
//   cursor_row/col/idx         : 3x3 cursor, idx = row*3+col
//   place_valid/idx/player     : one-cycle accepted-move pulse
//   turn, reject, ready        : next player, occupied-cell pulse, idle indicator
module move_arbiter #(
    parameter int LOCK_CYCLES = 52428800,
    parameter int CW          = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_sel,
    input  logic [8:0] occupied,
    input  logic       game_active,
    output logic [1:0] cursor_row,
    output logic [1:0] cursor_col,
    output logic [3:0] cursor_idx,
    output logic       place_valid,
    output logic [3:0] place_idx,
    output logic       place_player,
    output logic       turn,
    output logic       reject,
    output logic       ready
);
    typedef enum logic [1:0] {IDLE, HELD, LOCK} state_t;
    localparam logic [CW-1:0] LAST = CW'(LOCK_CYCLES - 1);
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    row_q, row_d, col_q, col_d;
    logic          turn_q, turn_d, pv_q, pv_d, pp_q, pp_d, rej_q, rej_d;
    logic [3:0]    pidx_q, pidx_d;
    logic          any;
    assign any        = btn_up | btn_down | btn_left | btn_right | btn_sel;
    assign cursor_row = row_q;
    assign cursor_col = col_q;
    assign cursor_idx = {2'b00, row_q} * 4'd3 + {2'b00, col_q};
    assign place_valid  = pv_q;
    assign place_idx    = pidx_q;
    assign place_player = pp_q;
    assign turn         = turn_q;
    assign reject       = rej_q;
    assign ready        = state_q == IDLE;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        turn_d  = turn_q;
        pidx_d  = pidx_q;
        pp_d    = pp_q;
        pv_d    = 1'b0;
        rej_d   = 1'b0;
        case (state_q)
            IDLE: if (any) begin
                state_d = HELD;
                if (game_active) begin
                    if (btn_sel) begin
                        if (occupied[cursor_idx]) rej_d = 1'b1;
                        else begin
                            pv_d   = 1'b1;
                            pidx_d = cursor_idx;
                            pp_d   = turn_q;
                            turn_d = ~turn_q;
                        end
                    end
                    else if (btn_up)   row_d = row_q == 2'd0 ? 2'd2 : row_q - 2'd1;
                    else if (btn_down) row_d = row_q == 2'd2 ? 2'd0 : row_q + 2'd1;
                    else if (btn_left) col_d = col_q == 2'd0 ? 2'd2 : col_q - 2'd1;
                    else               col_d = col_q == 2'd2 ? 2'd0 : col_q + 2'd1;
                end
            end
            HELD: if (!any) begin
                state_d = LOCK;
                cnt_d   = '0;
            end
            default: begin
                // a new press restarts the whole lockout from the next release
                if (any) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end
                else if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
                else cnt_d = cnt_q + 1'b1;
            end
        endcase
        if (!game_active) turn_d = 1'b0;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            row_q   <= 2'd1;
            col_q   <= 2'd1;
            turn_q  <= 1'b0;
            pv_q    <= 1'b0;
            pidx_q  <= 4'd0;
            pp_q    <= 1'b0;
            rej_q   <= 1'b0;
        end
        else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            turn_q  <= turn_d;
            pv_q    <= pv_d;
            pidx_q  <= pidx_d;
            pp_q    <= pp_d;
            rej_q   <= rej_d;
        end
    end
endmodule

// File: tb/tb_move_arbiter.sv
// tb_move_arbiter: randomized and directed checks of move_arbiter against a behavioural model.
module tb_move_arbiter;
    localparam int L = 4;
    logic       clk = 1'b0, rst = 1'b0;
    logic       b_up = 0, b_down = 0, b_left = 0, b_right = 0, b_sel = 0;
    logic [8:0] occ = '0;
    logic       ga = 1'b1;
    logic [1:0] cursor_row, cursor_col;
    logic [3:0] cursor_idx, place_idx;
    logic       place_valid, place_player, turn, reject, ready;
    int checks = 0, errors = 0;
    int m_row, m_col, m_turn, m_pv, m_pidx, m_pp, m_rej, m_quiet;
    bit m_busy;
    move_arbiter #(.LOCK_CYCLES(L), .CW(3)) dut (
        .clk(clk), .rst(rst),
        .btn_up(b_up), .btn_down(b_down), .btn_left(b_left), .btn_right(b_right), .btn_sel(b_sel),
        .occupied(occ), .game_active(ga),
        .cursor_row(cursor_row), .cursor_col(cursor_col), .cursor_idx(cursor_idx),
        .place_valid(place_valid), .place_idx(place_idx), .place_player(place_player),
        .turn(turn), .reject(reject), .ready(ready)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic model_reset();
        m_row = 1; m_col = 1; m_turn = 0; m_pv = 0; m_pidx = 0; m_pp = 0; m_rej = 0;
        m_busy = 0; m_quiet = 0;
    endtask
    // A consumed press keeps the arbiter busy until L+1 consecutive released samples.
    task automatic model_step();
        int idx;
        bit any;
        any = b_up | b_down | b_left | b_right | b_sel;
        m_pv = 0; m_rej = 0;
        if (m_busy) begin
            if (any) m_quiet = 0;
            else if (m_quiet == L) begin m_busy = 0; m_quiet = 0; end
            else m_quiet++;
        end
        else if (any) begin
            m_busy = 1; m_quiet = 0;
            if (ga) begin
                idx = m_row * 3 + m_col;
                if (b_sel) begin
                    if (occ[idx]) m_rej = 1;
                    else begin m_pv = 1; m_pidx = idx; m_pp = m_turn; m_turn = 1 - m_turn; end
                end
                else if (b_up)   m_row = (m_row + 2) % 3;
                else if (b_down) m_row = (m_row + 1) % 3;
                else if (b_left) m_col = (m_col + 2) % 3;
                else             m_col = (m_col + 1) % 3;
            end
        end
        if (!ga) m_turn = 0;
    endtask
    task automatic check_outs();
        chk("row", cursor_row, m_row);
        chk("col", cursor_col, m_col);
        chk("idx", cursor_idx, m_row * 3 + m_col);
        chk("place_valid", place_valid, m_pv);
        chk("place_idx", place_idx, m_pidx);
        chk("place_player", place_player, m_pp);
        chk("turn", turn, m_turn);
        chk("reject", reject, m_rej);
        chk("ready", ready, !m_busy);
        chk("pv_rej_excl", place_valid & reject, 0);
    endtask
    task automatic cycle();
        @(posedge clk);
        if (!rst) model_reset(); else model_step();
        #1 check_outs();
        @(negedge clk);
    endtask
    task automatic do_reset();
        rst = 1'b0;
        #1 model_reset();
        check_outs();
        chk("rst_ready", ready, 1);
        chk("rst_idx", cursor_idx, 4);
        chk("rst_turn", turn, 0);
        cycle();
        rst = 1'b1;
    endtask
    task automatic set_btn(input logic [4:0] m);
        {b_sel, b_up, b_down, b_left, b_right} = m;
    endtask
    // mask order: sel, up, down, left, right
    task automatic press(input logic [4:0] m, input int hold, input bit wait_ready, output int n);
        set_btn(m);
        repeat (hold) cycle();
        set_btn(5'b0);
        n = 0;
        if (wait_ready) begin
            while (!ready && n < 40) begin cycle(); n++; end
            chk("lock_wait", ready, 1);
        end
    endtask
    initial begin
        int n, c0;
        model_reset();
        cycle();
        cycle();
        rst = 1'b1;
        press(5'b01000, 3, 1, n);
        chk("up1_idx", cursor_idx, 1);
        chk("lock_len", n, L + 1);
        press(5'b01000, 1, 1, n);
        chk("up2_wrap_idx", cursor_idx, 7);
        press(5'b00100, 1, 1, n);
        press(5'b00100, 1, 1, n);
        chk("centre_idx", cursor_idx, 4);
        occ = '0;
        press(5'b10000, 2, 1, n);
        chk("place_turn", turn, 1);
        occ = 9'b000010000;
        press(5'b10000, 1, 1, n);
        chk("reject_turn", turn, 1);
        occ = '0;
        press(5'b11001, 1, 1, n);
        chk("multi_idx", cursor_idx, 4);
        chk("multi_turn", turn, 0);
        press(5'b00010, 2, 0, n);
        c0 = m_col;
        repeat (3) cycle();
        press(5'b00010, 2, 1, n);
        chk("relock_len", n, L + 1);
        chk("no_second_grant", cursor_col, c0);
        occ = '0;
        if (m_turn == 0) press(5'b10000, 1, 1, n);
        for (int i = 0; i < 6 && !(m_row == 2 && m_col == 2); i++)
            press(m_row != 2 ? 5'b00100 : 5'b00001, 1, (m_row == 2 && m_col == 1) ? 0 : 1, n);
        chk("pre_rst_turn", turn, 1);
        chk("pre_rst_idx", cursor_idx, 8);
        repeat (2) cycle();
        do_reset();
        ga = 1'b0;
        press(5'b10000, 2, 1, n);
        chk("inactive_turn", turn, 0);
        chk("inactive_idx", cursor_idx, 4);
        ga = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) < 2) do_reset();
            else begin
                set_btn($urandom_range(99) < 35 ? 5'($urandom) : 5'b0);
                occ = 9'($urandom);
                ga  = $urandom_range(99) < 85;
                cycle();
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
